// File: rtl/dualcore_ram_arbiter.sv
// Shared single-port data RAM arbiter for the two pipeline cores.
// Optional contention counter enabled by defining ARB_CONFLICT_CNT_EN.
module dualcore_ram_arbiter #(
    parameter int ADDR_W        = 12,
    parameter int DATA_W        = 8,
    parameter int ACCESS_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_wen,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] rdata,
    output logic              done0,
    output logic              done1,
    output logic              stall0,
    output logic              stall1,
    output logic [15:0]       conflict_cnt
);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYCLES - 1);

    state_t            state;
    state_t            state_n;
    logic              owner;
    logic              last_grant;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q;
    logic [DATA_W-1:0] rdata_q;
    logic              done0_q;
    logic              done1_q;
    logic              grant;
    logic              winner;

    // Arbitration in IDLE, single write strobe on the last ACCESS cycle
    always_comb begin
        state_n = state;
        grant   = 1'b0;
        winner  = 1'b0;
        ram_wen = 1'b0;
        unique case (state)
            IDLE: begin
                if (req0 || req1) begin
                    grant   = 1'b1;
                    winner  = (req0 && req1) ? ~last_grant : req1;
                    state_n = ACCESS;
                end
            end
            ACCESS: begin
                ram_wen = we_q && (cnt == 4'd0);
                if (cnt == 4'd0) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State, latched request, access countdown, read capture and done pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= 4'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            rdata_q    <= '0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
        end else begin
            state   <= state_n;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            if (grant) begin
                owner      <= winner;
                last_grant <= winner;
                addr_q     <= winner ? addr1 : addr0;
                wdata_q    <= winner ? wdata1 : wdata0;
                we_q       <= winner ? we1 : we0;
                cnt        <= CNT_INIT;
            end else if (state == ACCESS) begin
                if (cnt != 4'd0) begin
                    cnt <= cnt - 4'd1;
                end else begin
                    if (!we_q) begin
                        rdata_q <= ram_rdata;
                    end
                    if (owner) begin
                        done1_q <= 1'b1;
                    end else begin
                        done0_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign rdata     = rdata_q;
    assign done0     = done0_q;
    assign done1     = done1_q;
    assign stall0    = req0 & ~done0_q;
    assign stall1    = req1 & ~done1_q;

`ifdef ARB_CONFLICT_CNT_EN
    logic [15:0] conflict_q;

    // Count grants taken while both cores were requesting, saturating
    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_q <= '0;
        end else if (grant && req0 && req1 && conflict_q != 16'hFFFF) begin
            conflict_q <= conflict_q + 16'd1;
        end
    end

    assign conflict_cnt = conflict_q;
`else
    assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_dualcore_ram_arbiter.sv
// Testbench for dualcore_ram_arbiter: transaction model plus directed checks.
// Set ARB_CONFLICT_CNT_EN to match the design build.
module tb_dualcore_ram_arbiter;

    localparam int AC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, we0, req1, we1;
    logic [11:0] addr0, addr1;
    logic [7:0]  wdata0, wdata1;
    logic [11:0] ram_addr;
    logic [7:0]  ram_wdata, ram_rdata, rdata;
    logic        ram_wen, done0, done1, stall0, stall1;
    logic [15:0] conflict_cnt;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] hash(input logic [11:0] a);
        return a[7:0] ^ 8'hB5;
    endfunction

    assign ram_rdata = hash(ram_addr);

    dualcore_ram_arbiter #(
        .ADDR_W(12),
        .DATA_W(8),
        .ACCESS_CYCLES(AC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req0(req0),
        .we0(we0),
        .addr0(addr0),
        .wdata0(wdata0),
        .req1(req1),
        .we1(we1),
        .addr1(addr1),
        .wdata1(wdata1),
        .ram_addr(ram_addr),
        .ram_wdata(ram_wdata),
        .ram_wen(ram_wen),
        .ram_rdata(ram_rdata),
        .rdata(rdata),
        .done0(done0),
        .done1(done1),
        .stall0(stall0),
        .stall1(stall1),
        .conflict_cnt(conflict_cnt)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transaction model: one job at a time, a job lasts AC cycles
    bit          busy, j_core, j_we, last, md0, md1, nd0, nd1;
    int          left;
    logic [11:0] m_addr;
    logic [7:0]  m_wdata, m_rdata;
    logic [15:0] m_cc;

    always @(posedge clk) begin
        if (rst) begin
            busy = 0; last = 1; left = 0; md0 = 0; md1 = 0;
            j_core = 0; j_we = 0;
            m_addr = 0; m_wdata = 0; m_rdata = 0; m_cc = 0;
        end else begin
            nd0 = 0;
            nd1 = 0;
            if (busy) begin
                if (left == 1) begin
                    busy = 0;
                    if (j_core) nd1 = 1; else nd0 = 1;
                    if (!j_we) m_rdata = hash(m_addr);
                end else begin
                    left--;
                end
            end else if (req0 || req1) begin
                j_core  = (req0 && req1) ? !last : req1;
                last    = j_core;
                busy    = 1;
                left    = AC;
                m_addr  = j_core ? addr1 : addr0;
                m_wdata = j_core ? wdata1 : wdata0;
                j_we    = j_core ? we1 : we0;
                if (req0 && req1 && m_cc != 16'hFFFF) m_cc++;
            end
            md0 = nd0;
            md1 = nd1;
        end
    end

    logic [15:0] cc_exp;
`ifdef ARB_CONFLICT_CNT_EN
    assign cc_exp = m_cc;
`else
    assign cc_exp = 16'h0;
`endif

    // Compare every output against the model each cycle
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_wen", ram_wen, busy && left == 1 && j_we);
            check("m_addr", ram_addr, m_addr);
            check("m_wdata", ram_wdata, m_wdata);
            check("m_done0", done0, md0);
            check("m_done1", done1, md1);
            check("m_stall0", stall0, req0 && !md0);
            check("m_stall1", stall1, req1 && !md1);
            check("m_rdata", rdata, m_rdata);
            check("m_cc", conflict_cnt, cc_exp);
        end
    end

    int q_who[$];
    int q_at[$];

    initial begin
        rst = 1; req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
        repeat (2) @(negedge clk);
        chk_en = 1;
        check("rst_wen", ram_wen, 0);
        check("rst_done", {done0, done1}, 0);
        check("rst_rdata", rdata, 0);
        check("rst_addr", ram_addr, 0);
        check("rst_cc", conflict_cnt, 0);
        #1 rst = 0;
        @(negedge clk);

        // core0 read 010
        #1 req0 = 1; we0 = 0; addr0 = 12'h010;
        @(negedge clk);
        check("s1_addr", ram_addr, 12'h010);
        check("s1_stall_a", stall0, 1);
        @(negedge clk);
        check("s1_stall_b", stall0, 1);
        check("s1_early", done0, 0);
        @(negedge clk);
        check("s1_done", done0, 1);
        check("s1_rdata", rdata, 8'hA5);
        check("s1_stall_end", stall0, 0);
        #1 req0 = 0;
        @(negedge clk);

        // core1 write 7F4 <= 3C
        #1 req1 = 1; we1 = 1; addr1 = 12'h7F4; wdata1 = 8'h3C;
        @(negedge clk);
        check("s2_wen_a", ram_wen, 0);
        @(negedge clk);
        check("s2_wen_b", ram_wen, 1);
        check("s2_addr", ram_addr, 12'h7F4);
        check("s2_wdata", ram_wdata, 8'h3C);
        @(negedge clk);
        check("s2_done", done1, 1);
        check("s2_wen_c", ram_wen, 0);
        check("s2_rdata", rdata, 8'hA5);
        #1 req1 = 0; we1 = 0;
        @(negedge clk);

        // both cores request continuously
        #1 req0 = 1; req1 = 1; addr0 = 12'h133; addr1 = 12'h2C0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done0) begin q_who.push_back(0); q_at.push_back(i); end
            if (done1) begin q_who.push_back(1); q_at.push_back(i); end
        end
        #1 req0 = 0; req1 = 0;
        check("s3_count", q_who.size(), 4);
        for (int k = 0; k < 4 && k < q_who.size(); k++) begin
            check("s3_order", q_who[k], k % 2);
            check("s3_time", q_at[k], 2 + 3 * k);
        end
`ifdef ARB_CONFLICT_CNT_EN
        check("s3_cc", conflict_cnt, 4);
`endif
        @(negedge clk);

        // core1 arrives one cycle after core0
        #1 req0 = 1; we0 = 1; addr0 = 12'h055; wdata0 = 8'h99;
        @(negedge clk);
        #1 req1 = 1; we1 = 0; addr1 = 12'h0AA;
        @(negedge clk);
        check("s4_stall1_a", stall1, 1);
        check("s4_done0_early", done0, 0);
        @(negedge clk);
        check("s4_done0", done0, 1);
        check("s4_stall1_b", stall1, 1);
        #1 req0 = 0; we0 = 0;
        @(negedge clk);
        check("s4_grant1", ram_addr, 12'h0AA);
        check("s4_stall1_c", stall1, 1);
        @(negedge clk);
        check("s4_stall1_d", stall1, 1);
        @(negedge clk);
        check("s4_done1", done1, 1);
        check("s4_rdata", rdata, 8'h1F);
        #1 req1 = 0;
        @(negedge clk);

        // reset in the middle of an access
        #1 req0 = 1; we0 = 0; addr0 = 12'h321;
        @(negedge clk);
        check("s5_addr", ram_addr, 12'h321);
        #1 rst = 1; req0 = 0;
        @(negedge clk);
        check("s5_wen", ram_wen, 0);
        check("s5_done", {done0, done1}, 0);
        check("s5_rdata", rdata, 0);
        check("s5_raddr", ram_addr, 0);
        check("s5_cc", conflict_cnt, 0);
        #1 rst = 0; req0 = 1; req1 = 1; addr0 = 12'h0E1; addr1 = 12'h0E2;
        @(negedge clk);
        check("s5_tie", ram_addr, 12'h0E1);
        @(negedge clk);
        @(negedge clk);
        check("s5_done0", done0, 1);
        check("s5_done1_no", done1, 0);
        #1 req0 = 0;
        repeat (3) @(negedge clk);
        check("s5_done1", done1, 1);
        #1 req1 = 0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dualcore_ram_arbiter.md
Name: dualcore_ram_arbiter

Overview:
- Arbitrates one shared single-port data RAM between the two pipeline cores of the dual-core design.
- Grants one access at a time, using round-robin on ties.
- Drives each core's stall line while that core's request is outstanding. The stall lines feed STALL_DUAL_CORE in the per-core PC counter, which holds or rewinds the PC.
- Sits between the two cores' memory stages and the RAM macro.

Parameters:
- ADDR_W, 12, RAM address width. Matches the 12-bit PC/jump address space.
- DATA_W, 8, RAM data width.
- ACCESS_CYCLES, 1, number of cycles the RAM needs per access. Legal range 1..15.

Ports:
- clk  in  1  system clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- req0  in  1  core 0 requests RAM access; held until done0
- we0  in  1  core 0 access is a write (1) or a read (0)
- addr0  in  ADDR_W  core 0 address
- wdata0  in  DATA_W  core 0 write data
- req1, we1, addr1, wdata1  in  1/1/ADDR_W/DATA_W  same as the core 0 group, for core 1
- ram_addr  out  ADDR_W  address to RAM
- ram_wdata  out  DATA_W  write data to RAM
- ram_wen  out  1  RAM write enable
- ram_rdata  in  DATA_W  RAM read data, valid in the last ACCESS cycle
- rdata  out  DATA_W  captured read data, shared by both cores
- done0, done1  out  1  one-cycle completion pulse per core
- stall0, stall1  out  1  stall to core 0 / core 1
- conflict_cnt  out  16  contention counter (see Optional Feature)

Behaviour:
- States: IDLE, ACCESS. Registers:
  - owner (1 bit), last_grant (1 bit), cnt (4 bit)
  - latched addr_q, wdata_q, we_q
  - rdata_q; done0/done1 registers
- Reset values:
  - state=IDLE, owner=0, last_grant=1 (core 0 wins the first tie), cnt=0
  - addr_q, wdata_q, we_q, rdata_q = 0; done0=done1=0; conflict_cnt=0
  - ram_wen=0; ram_addr=0; ram_wdata=0; rdata=0
  - stall0/stall1 follow their formula, so they are 0 when req is 0
- IDLE:
  - No request: stay in IDLE.
  - Exactly one req: grant that core.
  - Both req: grant !last_grant.
  - On grant: owner<=winner, last_grant<=winner, latch winner's addr/we/wdata, cnt<=ACCESS_CYCLES-1, go to ACCESS.
  - Arbitration takes 0 extra cycles: a request seen in IDLE is granted on that edge.
- ACCESS:
  - ram_addr=addr_q and ram_wdata=wdata_q every cycle.
  - ram_wen=we_q only when cnt==0, so exactly one write strobe per access.
  - cnt!=0: cnt decrements.
  - cnt==0: rdata_q<=ram_rdata if !we_q; done[owner]<=1 for the next cycle; go to IDLE.
- Outside ACCESS: ram_wen=0; ram_addr/ram_wdata hold their last values.
- done is a registered one-cycle pulse, asserted in the IDLE cycle after the access.
  - rdata is valid in that cycle and holds until the next read completes.
  - Writes leave rdata unchanged.
- Stall: stall_x = req_x & ~done_x (combinational).
  - A requesting core stalls from its first request cycle through the cycle before done_x.
  - Minimum stall is ACCESS_CYCLES+1 cycles.
- Back-to-back: in the done cycle (IDLE), the arbiter may grant a new request on the same edge.
  - A core must drop or change its req in the done cycle. A req still asserted then is treated as a new request.
- Latency: an uncontended request sees done after ACCESS_CYCLES+1 cycles.
  - A contended loser waits for one additional full access.
- Fairness: round-robin guarantees each core at most one waiting access while both continuously request.
- Request dropped during ACCESS: the access still completes and done pulses; the core ignores it.
  - Request inputs are ignored during ACCESS; only latched values are used.
- Request dropped in IDLE before grant: no effect.
- rst mid-ACCESS: access is abandoned, no done pulse, all registers return to reset values on that edge.
  - ram_wen deasserts in the cycle after the reset edge.

Optional Feature:
- Macro ARB_CONFLICT_CNT_EN.
- Defined: conflict_cnt increments by 1 on every IDLE grant taken while req0 and req1 are both high.
  - Saturates at 16'hFFFF; cleared only by rst.
- Undefined: no counter logic; conflict_cnt is tied to 0. The port remains in the interface.

Test Plan:
- ACCESS_CYCLES=1; rst, then core0 read addr 12'h010 with ram_rdata=8'hA5 -> ram_addr=12'h010 in the cycle after req; done0 two cycles after req; rdata=8'hA5; stall0 high exactly 2 cycles; ram_wen never high.
- ACCESS_CYCLES=2; core1 write addr 12'h7F4 data 8'h3C -> ram_wen high exactly 1 cycle, the second ACCESS cycle, with ram_addr=12'h7F4 and ram_wdata=8'h3C; done1 pulses the following cycle.
- Both cores request in the same cycle, continuously, after reset -> grant order core0, core1, core0, core1. Each done pulses alternately every ACCESS_CYCLES+1 cycles. With ARB_CONFLICT_CNT_EN, conflict_cnt increments on each of those grants.
- Core0 requests; core1 requests one cycle later -> core1 stalls until core0's done; core1 is granted on the done0 edge; done1 follows ACCESS_CYCLES+1 cycles after done0.
- rst asserted during ACCESS (ACCESS_CYCLES=3, cnt=1) -> no done pulse; next cycle state=IDLE, ram_wen=0, rdata=0, conflict_cnt=0. A request after rst is granted to core0 on a tie.
- ARB_CONFLICT_CNT_EN defined, counter preloaded near saturation via 65535 contended grants -> conflict_cnt holds at 16'hFFFF on further conflicts.
